// File: rtl/sat_pkg.sv
// Shared constants and walker state encoding for the clause-fetch pipeline.
package sat_pkg;
   localparam int MAX_CLAUSES_PER_VARIABLE = 20;
   localparam int LITERAL_ADDRESS_WIDTH    = 11;
   localparam int CNT_WIDTH                = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      DONE = 2'd2
   } walker_state_t;
endpackage

// File: rtl/lsb_priority_encoder.sv
// Finds the index of the lowest set bit of a mask plus an any-set flag.
module lsb_priority_encoder #(
   parameter int WIDTH = 20,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] mask,
   output logic [IDX_W-1:0] index,
   output logic             any_set
);
   always_comb begin
      index = '0;
      // Scan downward so the lowest set bit is the last assignment to stick.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) index = IDX_W'(i);
      end
      any_set = |mask;
   end
endmodule

// File: rtl/clause_list_walker.sv
// Walks a literal's clause-slot mask lowest-first, emitting base+slot per set bit,
// then pulses done_o with the number of clauses issued.
module clause_list_walker
   import sat_pkg::*;
(
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [LITERAL_ADDRESS_WIDTH:0]     literal_i,
   input  logic [LITERAL_ADDRESS_WIDTH-1:0]   address_i,
   input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_i,
   input  logic                               flush_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [LITERAL_ADDRESS_WIDTH-1:0]   clause_addr_o,
   output logic [CNT_WIDTH-1:0]               slot_o,
   output logic [LITERAL_ADDRESS_WIDTH:0]     literal_o,
   output logic                               done_o,
   output logic [CNT_WIDTH-1:0]               count_o
);
   walker_state_t                        state_reg, state_next;
   logic [LITERAL_ADDRESS_WIDTH-1:0]     base_reg;
   logic [MAX_CLAUSES_PER_VARIABLE-1:0]  mask_reg;
   logic [MAX_CLAUSES_PER_VARIABLE-1:0]  mask_cleared;
   logic [LITERAL_ADDRESS_WIDTH:0]       literal_reg;
   logic [CNT_WIDTH-1:0]                 counter_reg;
   logic [CNT_WIDTH-1:0]                 slot;
   logic                                 any_set;
   logic                                 accept;
   logic                                 emit;

   lsb_priority_encoder #(
      .WIDTH (MAX_CLAUSES_PER_VARIABLE),
      .IDX_W (CNT_WIDTH)
   ) u_lsb_enc (
      .mask    (mask_reg),
      .index   (slot),
      .any_set (any_set)
   );

   // Dropping the lowest set bit is the same as clearing the bit at 'slot'.
   assign mask_cleared = mask_reg & (mask_reg - MAX_CLAUSES_PER_VARIABLE'(1));
   assign accept       = (state_reg == IDLE) && req_valid_i;
   assign emit         = out_valid_o && out_ready_i;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (req_valid_i) state_next = (mask_i != '0) ? WALK : DONE;
         WALK: if (out_ready_i && (mask_cleared == '0)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         base_reg    <= '0;
         mask_reg    <= '0;
         literal_reg <= '0;
         counter_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept && !flush_i) begin
            base_reg    <= address_i;
            mask_reg    <= mask_i;
            literal_reg <= literal_i;
            counter_reg <= '0;
         end
         // A handshake coinciding with flush still counts as delivered.
         if (emit) begin
            counter_reg <= counter_reg + CNT_WIDTH'(1);
            mask_reg    <= mask_cleared;
         end
         if (flush_i) mask_reg <= '0;
      end
   end

   assign req_ready_o   = (state_reg == IDLE);
   assign out_valid_o   = (state_reg == WALK) && any_set;
   assign done_o        = (state_reg == DONE);
   assign count_o       = counter_reg;
   assign slot_o        = slot;
   assign clause_addr_o = base_reg + LITERAL_ADDRESS_WIDTH'(slot);
   assign literal_o     = literal_reg;
endmodule

// File: tb/tb_clause_list_walker.sv
// Directed bench for clause_list_walker with an emission/completion scoreboard.
module tb_clause_list_walker;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [11:0] literal_i;
   logic [10:0] address_i;
   logic [19:0] mask_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [10:0] clause_addr_o;
   logic [4:0]  slot_o;
   logic [11:0] literal_o;
   logic        done_o;
   logic [4:0]  count_o;

   typedef struct {
      logic [10:0] addr;
      logic [4:0]  slot;
      logic [11:0] lit;
   } exp_t;

   exp_t        exp_q[$];
   logic [4:0]  cnt_q[$];
   int          compared   = 0;
   int          mismatched = 0;

   clause_list_walker dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .literal_i     (literal_i),
      .address_i     (address_i),
      .mask_i        (mask_i),
      .flush_i       (flush_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .clause_addr_o (clause_addr_o),
      .slot_o        (slot_o),
      .literal_o     (literal_o),
      .done_o        (done_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every handshake and every done pulse must match a queued expectation.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (out_valid_o && out_ready_i) begin
            check("emit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("emit_addr", 32'(clause_addr_o), 32'(e.addr));
               check("emit_slot", 32'(slot_o), 32'(e.slot));
               check("emit_literal", 32'(literal_o), 32'(e.lit));
               $display("emit addr=0x%03h slot=%0d literal=0x%03h", clause_addr_o, slot_o, literal_o);
            end
         end
         if (done_o) begin
            check("done_expected", 32'(cnt_q.size() != 0), 32'd1);
            if (cnt_q.size() != 0) begin
               logic [4:0] c;
               c = cnt_q.pop_front();
               check("done_count", 32'(count_o), 32'(c));
               $display("done count=%0d", count_o);
            end
         end
      end
   end

   // Accepts one request; queues the first n_expect emissions and optionally a done count.
   task automatic send(input logic [10:0] addr, input logic [19:0] mask, input logic [11:0] lit,
                       input int n_expect, input bit expect_done);
      bit ready_seen = 0;
      int pushed = 0;
      int pop = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready_o) begin
            ready_seen = 1;
            break;
         end
      end
      check("req_ready_wait", 32'(ready_seen), 32'd1);
      for (int k = 0; k < 20; k++) begin
         if (mask[k]) begin
            pop++;
            if (pushed < n_expect) begin
               exp_t e;
               e.addr = addr + 11'(k);
               e.slot = 5'(k);
               e.lit  = lit;
               exp_q.push_back(e);
               pushed++;
            end
         end
      end
      if (expect_done) cnt_q.push_back(5'(pop));
      @(posedge clk);
      #1;
      req_valid_i = 1'b1;
      address_i   = addr;
      mask_i      = mask;
      literal_i   = lit;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      $display("request addr=0x%03h mask=0x%05h literal=0x%03h", addr, mask, lit);
   endtask

   task automatic wait_idle(input string tag);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready_o && exp_q.size() == 0 && cnt_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      req_valid_i = 1'b0;
      literal_i   = '0;
      address_i   = '0;
      mask_i      = '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_addr", 32'(clause_addr_o), 32'd0);
      check("rst_slot", 32'(slot_o), 32'd0);
      check("rst_literal", 32'(literal_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Sparse mask: slots 0 and 2, cycle-accurate latency
      send(11'h040, 20'h00005, 12'd7, 99, 1);
      @(negedge clk);
      check("sparse_first_valid", 32'(out_valid_o), 32'd1);
      check("sparse_first_addr", 32'(clause_addr_o), 32'h040);
      @(negedge clk);
      check("sparse_second_addr", 32'(clause_addr_o), 32'h042);
      @(negedge clk);
      check("sparse_done_timing", 32'(done_o), 32'd1);
      check("sparse_no_valid_in_done", 32'(out_valid_o), 32'd0);
      @(negedge clk);
      check("sparse_ready_return", 32'(req_ready_o), 32'd1);
      check("sparse_done_one_cycle", 32'(done_o), 32'd0);
      wait_idle("sparse_idle");

      // Backpressure: out_ready 1-0-0-1 on mask 0x80001
      send(11'h100, 20'h80001, 12'h5A5, 99, 1);
      @(negedge clk);
      check("bp_first_addr", 32'(clause_addr_o), 32'h100);
      @(posedge clk);
      #1 out_ready_i = 1'b0;
      @(negedge clk);
      check("bp_stall1_addr", 32'(clause_addr_o), 32'h113);
      check("bp_stall1_slot", 32'(slot_o), 32'd19);
      check("bp_stall1_valid", 32'(out_valid_o), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_stall2_addr", 32'(clause_addr_o), 32'h113);
      check("bp_stall2_valid", 32'(out_valid_o), 32'd1);
      check("bp_stall2_no_done", 32'(done_o), 32'd0);
      @(posedge clk);
      #1 out_ready_i = 1'b1;
      @(negedge clk);
      check("bp_release_addr", 32'(clause_addr_o), 32'h113);
      @(negedge clk);
      check("bp_done", 32'(done_o), 32'd1);
      wait_idle("bp_idle");

      // Empty mask
      send(11'h055, 20'h00000, 12'h00A, 99, 1);
      @(negedge clk);
      check("empty_done", 32'(done_o), 32'd1);
      check("empty_no_valid", 32'(out_valid_o), 32'd0);
      check("empty_count", 32'(count_o), 32'd0);
      @(negedge clk);
      check("empty_ready_return", 32'(req_ready_o), 32'd1);
      wait_idle("empty_idle");

      // Full mask with address wrap
      send(11'h7F0, 20'hFFFFF, 12'hFFF, 99, 1);
      wait_idle("full_idle");

      // Flush after third emission
      send(11'h200, 20'hFFFFF, 12'h123, 3, 0);
      repeat (3) @(posedge clk);
      #1;
      flush_i     = 1'b1;
      out_ready_i = 1'b0;
      @(posedge clk);
      #1;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      check("flush_idle_ready", 32'(req_ready_o), 32'd1);
      check("flush_no_valid", 32'(out_valid_o), 32'd0);
      check("flush_no_done", 32'(done_o), 32'd0);
      repeat (3) @(negedge clk);
      check("flush_queue_drained", 32'(exp_q.size()), 32'd0);
      send(11'h010, 20'h00012, 12'h044, 99, 1);
      wait_idle("post_flush_idle");

      // Reset pulsed mid-walk after two emissions
      send(11'h300, 20'hFFFFF, 12'h321, 2, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid_o), 32'd0);
      check("midrst_ready", 32'(req_ready_o), 32'd1);
      check("midrst_addr", 32'(clause_addr_o), 32'd0);
      check("midrst_literal", 32'(literal_o), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_done", 32'(done_o), 32'd0);
      check("midrst_queue_drained", 32'(exp_q.size()), 32'd0);
      send(11'h3FE, 20'h0000C, 12'h800, 99, 1);
      wait_idle("post_reset_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
